// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its benches.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_t;

  localparam int INSN_BYTES = 4;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory, redirect and decode signals around the fetch stage.
interface fetch_unit_if #(
  parameter int INSN_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [PC_WIDTH-1:0]   imem_req_addr;
  logic                  imem_resp_valid;
  logic [INSN_WIDTH-1:0] imem_resp_data;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [INSN_WIDTH-1:0] dec_insn;
  logic [PC_WIDTH-1:0]   dec_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output dec_valid,
    input  dec_ready,
    output dec_insn,
    output dec_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  dec_valid,
    output dec_ready,
    input  dec_insn,
    input  dec_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// In-order fetch stage: one outstanding imem request, word handed to decode,
// redirects discard any stale in-flight response.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   INSN_WIDTH = 32,
  parameter int                   PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  fetch_state_t          state;
  fetch_state_t          next_state;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   pc_next;
  logic [INSN_WIDTH-1:0] insn_q;
  logic                  load_insn;
  logic                  req_valid_c;
  logic                  dec_valid_c;
  logic [PC_WIDTH-1:0]   redirect_aligned;

  assign redirect_aligned = bus.redirect_pc & ~PC_WIDTH'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      insn_q <= '0;
    end else begin
      state <= next_state;
      pc    <= pc_next;
      if (load_insn) begin
        insn_q <= bus.imem_resp_data;
      end
    end
  end

  // Redirect outranks every other event; it always reloads the PC and picks
  // S_DROP whenever a request for the old PC is still owed a response.
  always_comb begin
    next_state  = state;
    pc_next     = pc;
    load_insn   = 1'b0;
    req_valid_c = 1'b0;
    dec_valid_c = 1'b0;
    unique case (state)
      S_REQ: begin
        req_valid_c = 1'b1;
        if (bus.redirect_valid) begin
          next_state = bus.imem_req_ready ? S_DROP : S_REQ;
        end else if (bus.imem_req_ready) begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          next_state = bus.imem_resp_valid ? S_REQ : S_DROP;
        end else if (bus.imem_resp_valid) begin
          load_insn  = 1'b1;
          next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        dec_valid_c = ~bus.redirect_valid;
        if (bus.redirect_valid) begin
          next_state = S_REQ;
        end else if (bus.dec_ready) begin
          pc_next    = pc + PC_WIDTH'(INSN_BYTES);
          next_state = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_resp_valid) begin
          next_state = S_REQ;
        end
      end
      default: next_state = S_REQ;
    endcase
    if (bus.redirect_valid) begin
      pc_next = redirect_aligned;
    end
  end

  assign bus.imem_req_valid = req_valid_c & ~rst;
  assign bus.imem_req_addr  = pc;
  assign bus.dec_valid      = dec_valid_c & ~rst;
  assign bus.dec_insn       = insn_q;
  assign bus.dec_pc         = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// asynchronous-reset sequences.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        redir;
    logic [31:0] redir_pc;
    logic        dec_ready;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_dec_valid;
    logic [31:0] exp_insn;
    logic [31:0] exp_pc;
  } vec_t;

  localparam logic [31:0] NOP  = RV32_NOP;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_count = 0;
  int   check_count = 0;
  vec_t vecs[$];

  fetch_unit_if #(.INSN_WIDTH(32), .PC_WIDTH(32)) bus ();

  fetch_unit #(
    .INSN_WIDTH(32),
    .PC_WIDTH  (32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic addRow(input logic r, input logic rdy, input logic rv,
                        input logic [31:0] rdata, input logic rd,
                        input logic [31:0] rpc, input logic dr,
                        input logic erv, input logic [31:0] eaddr,
                        input logic edv, input logic [31:0] einsn,
                        input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.req_ready = rdy; v.resp_valid = rv; v.resp_data = rdata;
    v.redir = rd; v.redir_pc = rpc; v.dec_ready = dr;
    v.exp_req_valid = erv; v.exp_addr = eaddr; v.exp_dec_valid = edv;
    v.exp_insn = einsn; v.exp_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst                 = v.rst;
    bus.imem_req_ready  = v.req_ready;
    bus.imem_resp_valid = v.resp_valid;
    bus.imem_resp_data  = v.resp_data;
    bus.redirect_valid  = v.redir;
    bus.redirect_pc     = v.redir_pc;
    bus.dec_ready       = v.dec_ready;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    compare($sformatf("row%0d req_valid", idx), 32'(bus.imem_req_valid), 32'(v.exp_req_valid));
    compare($sformatf("row%0d req_addr", idx), bus.imem_req_addr, v.exp_addr);
    compare($sformatf("row%0d dec_valid", idx), 32'(bus.dec_valid), 32'(v.exp_dec_valid));
    if (v.exp_dec_valid) begin
      compare($sformatf("row%0d dec_insn", idx), bus.dec_insn, v.exp_insn);
      compare($sformatf("row%0d dec_pc", idx), bus.dec_pc, v.exp_pc);
    end
  endtask

  task automatic idleInputs();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.dec_ready       = 1'b0;
  endtask

  initial begin
    idleInputs();

    // Back-to-back NOPs from reset with a 1-cycle memory.
    addRow(1,0,0,0,0,0,0, 0,32'h0,0,0,0);
    addRow(0,1,0,0,0,0,1, 1,32'h0,0,0,0);
    addRow(0,1,1,NOP,0,0,1, 0,32'h0,0,0,0);
    addRow(0,1,0,0,0,0,1, 0,32'h0,1,NOP,32'h0);
    addRow(0,1,0,0,0,0,1, 1,32'h4,0,0,0);
    addRow(0,1,1,NOP,0,0,1, 0,32'h4,0,0,0);
    addRow(0,1,0,0,0,0,1, 0,32'h4,1,NOP,32'h4);
    addRow(0,1,0,0,0,0,1, 1,32'h8,0,0,0);
    addRow(0,1,1,NOP,0,0,1, 0,32'h8,0,0,0);
    addRow(0,1,0,0,0,0,1, 0,32'h8,1,NOP,32'h8);
    // Decode backpressure for five cycles.
    addRow(0,1,0,0,0,0,0, 1,32'hC,0,0,0);
    addRow(0,1,1,ADDI,0,0,0, 0,32'hC,0,0,0);
    for (int i = 0; i < 5; i++) addRow(0,1,0,0,0,0,0, 0,32'hC,1,ADDI,32'hC);
    addRow(0,1,0,0,0,0,1, 0,32'hC,1,ADDI,32'hC);
    // Memory stalls the request, then answers late; spurious response in REQ.
    addRow(0,0,0,0,0,0,1, 1,32'h10,0,0,0);
    addRow(0,0,0,0,0,0,1, 1,32'h10,0,0,0);
    addRow(0,1,0,0,0,0,1, 1,32'h10,0,0,0);
    addRow(0,0,0,0,0,0,1, 0,32'h10,0,0,0);
    addRow(0,0,1,32'h1111_1111,0,0,1, 0,32'h10,0,0,0);
    addRow(0,0,0,0,0,0,1, 0,32'h10,1,32'h1111_1111,32'h10);
    addRow(0,0,1,32'h0BAD_0BAD,0,0,1, 1,32'h14,0,0,0);
    addRow(0,0,0,0,0,0,1, 1,32'h14,0,0,0);
    // Redirect to 0x100 on the cycle the request for 0x8 is accepted.
    addRow(1,0,0,0,0,0,0, 0,32'h0,0,0,0);
    addRow(0,1,0,0,0,0,1, 1,32'h0,0,0,0);
    addRow(0,1,1,NOP,0,0,1, 0,32'h0,0,0,0);
    addRow(0,1,0,0,0,0,1, 0,32'h0,1,NOP,32'h0);
    addRow(0,1,0,0,0,0,1, 1,32'h4,0,0,0);
    addRow(0,1,1,NOP,0,0,1, 0,32'h4,0,0,0);
    addRow(0,1,0,0,0,0,1, 0,32'h4,1,NOP,32'h4);
    addRow(0,1,0,0,1,32'h100,1, 1,32'h8,0,0,0);
    addRow(0,1,0,0,0,0,1, 0,32'h100,0,0,0);
    addRow(0,1,1,DEAD,0,0,1, 0,32'h100,0,0,0);
    addRow(0,1,0,0,0,0,1, 1,32'h100,0,0,0);
    addRow(0,1,1,NOP,0,0,1, 0,32'h100,0,0,0);
    addRow(0,1,0,0,0,0,1, 0,32'h100,1,NOP,32'h100);
    // Redirect in HOLD while decode is ready: no transfer, unaligned target.
    addRow(0,1,0,0,0,0,1, 1,32'h104,0,0,0);
    addRow(0,1,1,32'h00A0_0113,0,0,1, 0,32'h104,0,0,0);
    addRow(0,0,0,0,1,32'h203,1, 0,32'h104,0,0,0);
    addRow(0,0,0,0,0,0,1, 1,32'h200,0,0,0);
    // Redirect in REQ without handshake, then PC wrap past the top.
    addRow(0,0,0,0,1,32'hFFFF_FFFC,1, 1,32'h200,0,0,0);
    addRow(0,1,0,0,0,0,1, 1,32'hFFFF_FFFC,0,0,0);
    addRow(0,1,1,NOP,0,0,1, 0,32'hFFFF_FFFC,0,0,0);
    addRow(0,0,0,0,0,0,1, 0,32'hFFFF_FFFC,1,NOP,32'hFFFF_FFFC);
    addRow(0,0,0,0,0,0,1, 1,32'h0,0,0,0);
    // Redirect in WAIT with and without a response, repeated redirect in DROP.
    addRow(0,1,0,0,0,0,1, 1,32'h0,0,0,0);
    addRow(0,0,1,DEAD,1,32'h40,1, 0,32'h0,0,0,0);
    addRow(0,1,0,0,0,0,1, 1,32'h40,0,0,0);
    addRow(0,0,0,0,1,32'h81,1, 0,32'h40,0,0,0);
    addRow(0,0,0,0,1,32'hC0,1, 0,32'h80,0,0,0);
    addRow(0,0,1,DEAD,0,0,1, 0,32'hC0,0,0,0);
    addRow(0,1,0,0,0,0,1, 1,32'hC0,0,0,0);
    addRow(0,0,1,32'h1234_5678,0,0,0, 0,32'hC0,0,0,0);
    addRow(0,0,1,32'hFFFF_FFFF,0,0,0, 0,32'hC0,1,32'h1234_5678,32'hC0);
    addRow(0,0,0,0,0,0,1, 0,32'hC0,1,32'h1234_5678,32'hC0);
    addRow(0,1,0,0,0,0,1, 1,32'hC4,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    // Asynchronous reset in the middle of S_WAIT (request for 0xC4 in flight).
    @(negedge clk);
    idleInputs();
    #1 compare("wait req_valid", 32'(bus.imem_req_valid), 32'd0);
    #1 rst = 1'b1;
    #1 compare("wait rst addr", bus.imem_req_addr, 32'h0);
    compare("wait rst dec_valid", 32'(bus.dec_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 compare("release req_valid", 32'(bus.imem_req_valid), 32'd1);
    compare("release addr", bus.imem_req_addr, 32'h0);

    // Reset mid-cycle while a request is being offered drops valid at once.
    #2 rst = 1'b1;
    #1 compare("req rst req_valid", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = ADDI;
    @(negedge clk);
    idleInputs();
    #1 compare("hold dec_valid", 32'(bus.dec_valid), 32'd1);
    compare("hold dec_insn", bus.dec_insn, ADDI);
    #1 rst = 1'b1;
    #1 compare("hold rst dec_valid", 32'(bus.dec_valid), 32'd0);
    compare("hold rst insn", bus.dec_insn, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 compare("final req_valid", 32'(bus.imem_req_valid), 32'd1);
    compare("final addr", bus.imem_req_addr, 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
